// File: rtl/controle_fechadura_pkg.sv
// -----------------------------------------------------------------------------
// controle_fechadura_pkg
// Shared types and constants for the electronic lock.
//   senhaPac_t          : 20 packed BCD-like digits, digit [0] is the newest
//   DIGITO_*            : special digit codes produced by the keypad decoder
//   estado_fechadura_t  : lock sequencer states
//   max_int             : elaboration-time helper for counter sizing
// -----------------------------------------------------------------------------
package controle_fechadura_pkg;

    localparam int NUM_DIGITOS = 20;
    localparam int SENHA_W     = NUM_DIGITOS * 4;

    typedef logic [NUM_DIGITOS-1:0][3:0] senhaPac_t;

    localparam logic [3:0] DIGITO_VAZIO   = 4'hF;
    localparam logic [3:0] DIGITO_CANCELA = 4'hB;
    localparam logic [3:0] DIGITO_TIMEOUT = 4'hE;

    typedef enum logic [1:0] {
        ESPERA,
        VERIFICA,
        ABERTO,
        BLOQUEIO
    } estado_fechadura_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // True when every digit of the entry equals d (used for the decoder's
    // timeout and cancel markers).
    function automatic logic todos_iguais(input senhaPac_t s, input logic [3:0] d);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (s[i] != d) r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/controle_fechadura_comparador.sv
// -----------------------------------------------------------------------------
// comparador_senha
// Combinational password checker.
//   i_entrada      : latched keypad entry
//   i_master       : master password (always accepted)
//   i_usuarios     : NUM_USUARIOS user passwords, slot i at [80*i +: 80]
//   i_mask         : per-slot enable
//   o_match        : entry equals master or an enabled user password
//   o_comprimento  : count of contiguous non-F digits starting at digit [0]
// -----------------------------------------------------------------------------
module comparador_senha
    import controle_fechadura_pkg::*;
#(
    parameter int NUM_USUARIOS = 4
) (
    input  senhaPac_t                         i_entrada,
    input  senhaPac_t                         i_master,
    input  logic [NUM_USUARIOS*SENHA_W-1:0]   i_usuarios,
    input  logic [NUM_USUARIOS-1:0]           i_mask,
    output logic                              o_match,
    output logic [4:0]                        o_comprimento
);

    logic w_continua;

    always_comb begin
        o_match = (i_entrada == i_master);
        for (int i = 0; i < NUM_USUARIOS; i++) begin
            if (i_mask[i] && (i_entrada == i_usuarios[SENHA_W*i +: SENHA_W])) begin
                o_match = 1'b1;
            end
        end
    end

    // Length stops at the first padding digit; digits beyond a gap never count.
    always_comb begin
        o_comprimento = '0;
        w_continua    = 1'b1;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (w_continua && (i_entrada[i] != DIGITO_VAZIO)) begin
                o_comprimento = o_comprimento + 5'd1;
            end else begin
                w_continua = 1'b0;
            end
        end
    end

endmodule

// File: rtl/controle_fechadura.sv
// -----------------------------------------------------------------------------
// controle_fechadura
// Top-level sequencer of the electronic lock: takes completed keypad entries,
// verifies them, drives the bolt and enforces a lockout after repeated failures.
//   clk, rst       : clock, synchronous active-high reset
//   digitos_value  : entry from the keypad decoder (F-padded)
//   digitos_valid  : one-cycle pulse, entry complete
//   senha_master   : master password
//   senha_usuario  : user passwords, slot i at [80*i +: 80]
//   usuario_ativo  : user slot enable mask
//   porta_fechada  : door sensor, 1 = closed
//   teclado_en     : keypad decoder enable (low also resets the decoder)
//   tranca         : 1 = bolt engaged
//   bloqueado      : lockout indicator
//   bip            : one-cycle pulse on a successful unlock
//   tentativas     : consecutive failed attempts
// -----------------------------------------------------------------------------
module controle_fechadura
    import controle_fechadura_pkg::*;
#(
    parameter  int NUM_USUARIOS   = 4,
    parameter  int MIN_DIGITOS    = 4,
    parameter  int MAX_TENTATIVAS = 3,
    parameter  int T_ABERTO       = 5000,
    parameter  int T_BLOQUEIO     = 30000,
    localparam int TENT_W         = $clog2(MAX_TENTATIVAS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  senhaPac_t                       digitos_value,
    input  logic                            digitos_valid,
    input  senhaPac_t                       senha_master,
    input  logic [NUM_USUARIOS*SENHA_W-1:0] senha_usuario,
    input  logic [NUM_USUARIOS-1:0]         usuario_ativo,
    input  logic                            porta_fechada,
    output logic                            teclado_en,
    output logic                            tranca,
    output logic                            bloqueado,
    output logic                            bip,
    output logic [TENT_W-1:0]               tentativas
);

    localparam int CNT_W = $clog2(max_int(T_ABERTO, T_BLOQUEIO) + 1);

    estado_fechadura_t r_estado, w_estado_prox;
    senhaPac_t         r_entrada, w_entrada_prox;
    logic [CNT_W-1:0]  r_cnt, w_cnt_prox;
    logic [TENT_W-1:0] r_tent, w_tent_prox, w_tent_inc;
    logic              r_bip, w_bip_prox;
    logic              w_match;
    logic [4:0]        w_comprimento;

    comparador_senha #(
        .NUM_USUARIOS (NUM_USUARIOS)
    ) u_comparador (
        .i_entrada     (r_entrada),
        .i_master      (senha_master),
        .i_usuarios    (senha_usuario),
        .i_mask        (usuario_ativo),
        .o_match       (w_match),
        .o_comprimento (w_comprimento)
    );

    assign w_tent_inc = r_tent + TENT_W'(1);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_estado_prox  = r_estado;
        w_entrada_prox = r_entrada;
        w_cnt_prox     = '0;
        w_tent_prox    = r_tent;
        w_bip_prox     = 1'b0;

        unique case (r_estado)
            ESPERA: begin
                if (digitos_valid &&
                    !todos_iguais(digitos_value, DIGITO_TIMEOUT) &&
                    !todos_iguais(digitos_value, DIGITO_CANCELA)) begin
                    w_entrada_prox = digitos_value;
                    w_estado_prox  = VERIFICA;
                end
            end

            VERIFICA: begin
                if (w_comprimento < 5'(MIN_DIGITOS)) begin
                    w_estado_prox = ESPERA;
                end else if (w_match) begin
                    w_estado_prox = ABERTO;
                    w_tent_prox   = '0;
                    w_bip_prox    = 1'b1;
                end else begin
                    w_tent_prox   = w_tent_inc;
                    w_estado_prox = (w_tent_inc == TENT_W'(MAX_TENTATIVAS)) ? BLOQUEIO : ESPERA;
                end
            end

            ABERTO: begin
                // Counter parks at its last value while the door is still open.
                if (r_cnt == CNT_W'(T_ABERTO - 1)) begin
                    if (porta_fechada) w_estado_prox = ESPERA;
                    else               w_cnt_prox    = r_cnt;
                end else begin
                    w_cnt_prox = r_cnt + CNT_W'(1);
                end
            end

            BLOQUEIO: begin
                if (r_cnt == CNT_W'(T_BLOQUEIO - 1)) begin
                    w_estado_prox = ESPERA;
                    w_tent_prox   = '0;
                end else begin
                    w_cnt_prox = r_cnt + CNT_W'(1);
                end
            end

            default: w_estado_prox = ESPERA;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_estado  <= ESPERA;
            r_entrada <= '1;
            r_cnt     <= '0;
            r_tent    <= '0;
            r_bip     <= 1'b0;
        end else begin
            r_estado  <= w_estado_prox;
            r_entrada <= w_entrada_prox;
            r_cnt     <= w_cnt_prox;
            r_tent    <= w_tent_prox;
            r_bip     <= w_bip_prox;
        end
    end

    assign teclado_en = (r_estado == ESPERA);
    assign tranca     = (r_estado != ABERTO);
    assign bloqueado  = (r_estado == BLOQUEIO);
    assign bip        = r_bip;
    assign tentativas = r_tent;

endmodule

// File: tb/tb_controle_fechadura.sv
// -----------------------------------------------------------------------------
// tb_controle_fechadura
// Directed stimulus with a scoreboard: each scenario queues the output vector
// {teclado_en, tranca, bloqueado, bip, tentativas} expected at each cycle where
// it changes; the monitor compares every observed change against the queue.
// -----------------------------------------------------------------------------
module tb_controle_fechadura;
    import controle_fechadura_pkg::*;

    localparam int NU = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    senhaPac_t             digitos_value;
    logic                  digitos_valid = 1'b0;
    senhaPac_t             senha_master;
    logic [NU*SENHA_W-1:0] senha_usuario;
    logic [NU-1:0]         usuario_ativo;
    logic                  porta_fechada = 1'b1;
    logic                  teclado_en, tranca, bloqueado, bip;
    logic [1:0]            tentativas;

    controle_fechadura #(
        .NUM_USUARIOS   (NU),
        .MIN_DIGITOS    (4),
        .MAX_TENTATIVAS (3),
        .T_ABERTO       (10),
        .T_BLOQUEIO     (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid),
        .senha_master  (senha_master),
        .senha_usuario (senha_usuario),
        .usuario_ativo (usuario_ativo),
        .porta_fechada (porta_fechada),
        .teclado_en    (teclado_en),
        .tranca        (tranca),
        .bloqueado     (bloqueado),
        .bip           (bip),
        .tentativas    (tentativas)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] v;
    } esperado_t;

    esperado_t fila[$];
    int        checks   = 0;
    int        failures = 0;
    logic      fim      = 1'b0;
    logic [5:0] saida;

    assign saida = {teclado_en, tranca, bloqueado, bip, tentativas};

    function automatic senhaPac_t mk(input logic [31:0] d, input int n);
        senhaPac_t s;
        s = '1;
        for (int i = 0; i < n; i++) s[i] = d[4*i +: 4];
        return s;
    endfunction

    function automatic senhaPac_t todos(input logic [3:0] d);
        senhaPac_t s;
        for (int i = 0; i < NUM_DIGITOS; i++) s[i] = d;
        return s;
    endfunction

    task automatic push(input int c, input logic [5:0] v);
        esperado_t e;
        e.cyc = c;
        e.v   = v;
        fila.push_back(e);
    endtask

    task automatic inicio(output int c);
        @(negedge clk);
        c = cyc;
    endtask

    task automatic dispara(input senhaPac_t v);
        digitos_value = v;
        digitos_valid = 1'b1;
        @(negedge clk);
        digitos_valid = 1'b0;
    endtask

    task automatic ate(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: one comparison per observed output change (plus the reset state).
    initial begin
        logic [5:0] anterior;
        esperado_t  e;
        anterior = '0;
        @(negedge clk);
        while (!fim) begin
            if (cyc == 1 || saida !== anterior) begin
                checks++;
                if (fila.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, saida);
                end else begin
                    e = fila.pop_front();
                    if (e.cyc != cyc || e.v !== saida) begin
                        failures++;
                        $display("FAIL outputs cyc=%0d got=%b want=%b at cyc=%0d",
                                 cyc, saida, e.v, e.cyc);
                    end
                end
            end
            anterior = saida;
            @(negedge clk);
        end
        checks++;
        if (fila.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d want=0 (next want=%b at cyc=%0d)",
                     fila.size(), fila[0].v, fila[0].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Stimulus
    initial begin
        int c;
        senha_master  = mk(32'h1234, 4);
        senha_usuario = {mk(32'h0, 0), mk(32'h0, 0), mk(32'h9999, 4), mk(32'h5678, 4)};
        usuario_ativo = 4'b0001;
        digitos_value = '1;

        // Reset state: teclado_en=1, tranca=1, bloqueado=0, bip=0, tentativas=0
        push(1, 6'b110000);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Master unlock, door closed: bolt released 10 cycles
        inicio(c);
        push(c + 1,  6'b010000);
        push(c + 2,  6'b000100);
        push(c + 3,  6'b000000);
        push(c + 12, 6'b110000);
        dispara(mk(32'h1234, 4));
        ate(c + 14);

        // Inactive slot password counts as a failure
        inicio(c);
        push(c + 1, 6'b010000);
        push(c + 2, 6'b110001);
        dispara(mk(32'h9999, 4));
        ate(c + 4);

        // Active user slot unlocks and clears the failure count
        inicio(c);
        push(c + 1,  6'b010001);
        push(c + 2,  6'b000100);
        push(c + 3,  6'b000000);
        push(c + 12, 6'b110000);
        dispara(mk(32'h5678, 4));
        ate(c + 14);

        // Three failures -> lockout for 20 cycles; entry during lockout ignored
        inicio(c);
        push(c + 1, 6'b010000);
        push(c + 2, 6'b110001);
        dispara(mk(32'h0, 4));
        ate(c + 4);
        inicio(c);
        push(c + 1, 6'b010001);
        push(c + 2, 6'b110010);
        dispara(mk(32'h0, 4));
        ate(c + 4);
        inicio(c);
        push(c + 1,  6'b010010);
        push(c + 2,  6'b011011);
        push(c + 22, 6'b110000);
        dispara(mk(32'h0, 4));
        ate(c + 6);
        dispara(mk(32'h1234, 4));
        ate(c + 25);

        // One failure, then short / timeout / cancel entries leave the count alone
        inicio(c);
        push(c + 1, 6'b010000);
        push(c + 2, 6'b110001);
        dispara(mk(32'h0, 4));
        ate(c + 4);
        inicio(c);
        push(c + 1, 6'b010001);
        push(c + 2, 6'b110001);
        dispara(mk(32'h123, 3));
        ate(c + 4);
        inicio(c);
        dispara(todos(DIGITO_TIMEOUT));
        ate(c + 4);
        inicio(c);
        dispara(todos(DIGITO_CANCELA));
        ate(c + 4);
        inicio(c);
        push(c + 1,  6'b010001);
        push(c + 2,  6'b000100);
        push(c + 3,  6'b000000);
        push(c + 12, 6'b110000);
        dispara(mk(32'h1234, 4));
        ate(c + 14);

        // Door open at expiry, held open 7 more cycles, relock after closing
        inicio(c);
        porta_fechada = 1'b0;
        push(c + 1,  6'b010000);
        push(c + 2,  6'b000100);
        push(c + 3,  6'b000000);
        push(c + 19, 6'b110000);
        dispara(mk(32'h1234, 4));
        ate(c + 18);
        porta_fechada = 1'b1;
        ate(c + 21);

        // Reset in the middle of a lockout
        inicio(c);
        push(c + 1, 6'b010000);
        push(c + 2, 6'b110001);
        dispara(mk(32'h0, 4));
        ate(c + 4);
        inicio(c);
        push(c + 1, 6'b010001);
        push(c + 2, 6'b110010);
        dispara(mk(32'h0, 4));
        ate(c + 4);
        inicio(c);
        push(c + 1, 6'b010010);
        push(c + 2, 6'b011011);
        dispara(mk(32'h0, 4));
        ate(c + 7);
        rst = 1'b1;
        push(c + 8, 6'b110000);
        ate(c + 8);
        rst = 1'b0;
        ate(c + 12);

        fim = 1'b1;
    end

endmodule
